// File: rtl/stack_unit_pkg.sv
// stack_unit_pkg: shared stack-op codes, FSM encodings and default depth
package stack_unit_pkg;
   localparam logic [1:0] stackPointerDef  = 2'd0;
   localparam logic [1:0] stackPointerPush = 2'd1;
   localparam logic [1:0] stackPointerPop  = 2'd2;
   localparam logic [0:0] STK_IDLE = 1'b0;
   localparam logic [0:0] STK_HOLD = 1'b1;
   localparam int STK_DEPTH = 8;
endpackage

// File: rtl/stack_unit_if.sv
// stack_unit_if: MEM-stage stack command bus between control unit and stack
interface stack_unit_if #(parameter int DATA_W = 16, parameter int ADDR_W = 3);
   logic              enMem;
   logic              sigStackMem;
   logic [1:0]        sigNewSP;
   logic              sigAddData;
   logic [DATA_W-1:0] retAddr;
   logic [DATA_W-1:0] regData;
   logic [DATA_W-1:0] popData;
   logic              popValid;
   logic              fullFlag;
   logic              emptyFlag;
   logic [ADDR_W:0]   sp;
   logic              overflowErr;
   logic              underflowErr;
   modport master (
      output enMem, sigStackMem, sigNewSP, sigAddData, retAddr, regData,
      input  popData, popValid, fullFlag, emptyFlag, sp, overflowErr, underflowErr
   );
   modport slave (
      input  enMem, sigStackMem, sigNewSP, sigAddData, retAddr, regData,
      output popData, popValid, fullFlag, emptyFlag, sp, overflowErr, underflowErr
   );
endinterface

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x DATA_W storage with synchronous write and registered read
module stack_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/stack_unit.sv
// stack_unit: hardware return/data stack driven by MEM-stage stack commands
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = STK_DEPTH
) (
   input logic        clock,
   input logic        reset_n,
   stack_unit_if.slave bus
);
   logic [0:0]        state;
   logic [ADDR_W:0]   count;
   logic              popLoaded;
   logic              cmdSel;
   logic              doPush;
   logic              doPop;
   logic              isFull;
   logic              isEmpty;
   logic              we;
   logic              re;
   logic [DATA_W-1:0] rdata;

   always_comb begin
      cmdSel  = state == STK_IDLE && bus.enMem && bus.sigStackMem;
      doPush  = cmdSel && bus.sigNewSP == stackPointerPush;
      doPop   = cmdSel && bus.sigNewSP == stackPointerPop;
      isFull  = count == (ADDR_W+1)'(DEPTH);
      isEmpty = count == '0;
      we      = reset_n && doPush && !isFull;
      re      = reset_n && doPop && !isEmpty;
   end

   stack_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem (
      .clock (clock),
      .we    (we),
      .waddr (count[ADDR_W-1:0]),
      .wdata (bus.sigAddData ? bus.retAddr : bus.regData),
      .re    (re),
      .raddr (count[ADDR_W-1:0] - 1'b1),
      .rdata (rdata)
   );

   // HOLD swallows the rest of one enMem assertion so a held command runs once
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state            <= STK_IDLE;
         count            <= '0;
         popLoaded        <= 1'b0;
         bus.popValid     <= 1'b0;
         bus.overflowErr  <= 1'b0;
         bus.underflowErr <= 1'b0;
      end else begin
         state            <= state == STK_IDLE ? ((doPush || doPop) ? STK_HOLD : STK_IDLE) : (bus.enMem ? STK_HOLD : STK_IDLE);
         count            <= we ? count + 1'b1 : re ? count - 1'b1 : count;
         popLoaded        <= popLoaded || re;
         bus.popValid     <= re;
         bus.overflowErr  <= bus.overflowErr || (doPush && isFull);
         bus.underflowErr <= bus.underflowErr || (doPop && isEmpty);
      end
   end

   // storage has no reset, so popData reads as zero until the first pop lands
   assign bus.popData   = popLoaded ? rdata : '0;
   assign bus.fullFlag  = isFull;
   assign bus.emptyFlag = isEmpty;
   assign bus.sp        = count;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed self-checking bench for stack_unit
module tb_stack_unit;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int total = 0;
   int bad = 0;

   stack_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();
   stack_unit #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   always #5 clock = ~clock;

   task automatic idle();
      bus.enMem = 1'b0; bus.sigStackMem = 1'b0; bus.sigNewSP = 2'd0;
      bus.sigAddData = 1'b0; bus.retAddr = '0; bus.regData = '0;
   endtask

   // one command edge then one enMem=0 edge; the unselected source carries the inverse
   task automatic stackOp(input logic [1:0] op, input logic addData, input logic [15:0] data,
                          output logic pv, output logic [15:0] pd, output logic pvAfter);
      bus.enMem = 1'b1; bus.sigStackMem = 1'b1; bus.sigNewSP = op; bus.sigAddData = addData;
      bus.retAddr = addData ? data : ~data; bus.regData = addData ? ~data : data;
      @(posedge clock); #1;
      pv = bus.popValid; pd = bus.popData;
      idle();
      @(posedge clock); #1;
      pvAfter = bus.popValid;
   endtask

   task automatic test_reset();
      idle(); reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      total++; if (bus.emptyFlag !== 1'b1) begin bad++; $display("FAIL reset_empty got %b want 1", bus.emptyFlag); end
      total++; if (bus.fullFlag !== 1'b0) begin bad++; $display("FAIL reset_full got %b want 0", bus.fullFlag); end
      total++; if (bus.sp !== 4'd0) begin bad++; $display("FAIL reset_sp got %0d want 0", bus.sp); end
      total++; if (bus.popValid !== 1'b0) begin bad++; $display("FAIL reset_popValid got %b want 0", bus.popValid); end
      total++; if (bus.popData !== 16'h0) begin bad++; $display("FAIL reset_popData got %h want 0000", bus.popData); end
      total++; if (bus.overflowErr !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", bus.overflowErr); end
      total++; if (bus.underflowErr !== 1'b0) begin bad++; $display("FAIL reset_unf got %b want 0", bus.underflowErr); end
   endtask

   task automatic test_call();
      logic pv, pa; logic [15:0] pd;
      stackOp(2'd1, 1'b1, 16'h0042, pv, pd, pa);
      total++; if (bus.sp !== 4'd1) begin bad++; $display("FAIL call_sp got %0d want 1", bus.sp); end
      total++; if (bus.emptyFlag !== 1'b0) begin bad++; $display("FAIL call_empty got %b want 0", bus.emptyFlag); end
      stackOp(2'd2, 1'b0, 16'h0, pv, pd, pa);
      total++; if (pv !== 1'b1) begin bad++; $display("FAIL ret_popValid got %b want 1", pv); end
      total++; if (pd !== 16'h0042) begin bad++; $display("FAIL ret_popData got %h want 0042", pd); end
      total++; if (pa !== 1'b0) begin bad++; $display("FAIL ret_popValid_after got %b want 0", pa); end
      total++; if (bus.sp !== 4'd0) begin bad++; $display("FAIL ret_sp got %0d want 0", bus.sp); end
   endtask

   task automatic test_push_pop();
      logic pv, pa; logic [15:0] pd;
      logic [15:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
      for (int i = 0; i < 3; i++) stackOp(2'd1, 1'b0, vals[i], pv, pd, pa);
      total++; if (bus.sp !== 4'd3) begin bad++; $display("FAIL pp_sp got %0d want 3", bus.sp); end
      for (int i = 2; i >= 0; i--) begin
         stackOp(2'd2, 1'b0, 16'h0, pv, pd, pa);
         total++; if (pv !== 1'b1 || pd !== vals[i]) begin bad++; $display("FAIL pp_pop%0d got %b/%h want 1/%h", i, pv, pd, vals[i]); end
      end
      total++; if (bus.emptyFlag !== 1'b1) begin bad++; $display("FAIL pp_empty got %b want 1", bus.emptyFlag); end
   endtask

   task automatic test_full();
      logic pv, pa; logic [15:0] pd;
      for (int i = 1; i <= 8; i++) stackOp(2'd1, 1'b0, 16'(i), pv, pd, pa);
      total++; if (bus.fullFlag !== 1'b1) begin bad++; $display("FAIL full_flag got %b want 1", bus.fullFlag); end
      total++; if (bus.sp !== 4'd8) begin bad++; $display("FAIL full_sp got %0d want 8", bus.sp); end
      total++; if (bus.overflowErr !== 1'b0) begin bad++; $display("FAIL full_ovf_early got %b want 0", bus.overflowErr); end
      stackOp(2'd1, 1'b0, 16'hDEAD, pv, pd, pa);
      total++; if (bus.sp !== 4'd8) begin bad++; $display("FAIL ovf_sp got %0d want 8", bus.sp); end
      total++; if (bus.overflowErr !== 1'b1) begin bad++; $display("FAIL ovf_err got %b want 1", bus.overflowErr); end
      for (int i = 8; i >= 1; i--) begin
         stackOp(2'd2, 1'b0, 16'h0, pv, pd, pa);
         total++; if (pv !== 1'b1 || pd !== 16'(i)) begin bad++; $display("FAIL full_pop%0d got %b/%h want 1/%h", i, pv, pd, 16'(i)); end
      end
      total++; if (bus.emptyFlag !== 1'b1) begin bad++; $display("FAIL full_drain_empty got %b want 1", bus.emptyFlag); end
      total++; if (bus.overflowErr !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", bus.overflowErr); end
   endtask

   task automatic test_underflow();
      logic pv, pa; logic [15:0] pd;
      stackOp(2'd2, 1'b0, 16'h0, pv, pd, pa);
      total++; if (pv !== 1'b0) begin bad++; $display("FAIL unf_popValid got %b want 0", pv); end
      total++; if (pd !== 16'h0001) begin bad++; $display("FAIL unf_popData got %h want 0001", pd); end
      total++; if (bus.sp !== 4'd0) begin bad++; $display("FAIL unf_sp got %0d want 0", bus.sp); end
      total++; if (bus.underflowErr !== 1'b1) begin bad++; $display("FAIL unf_err got %b want 1", bus.underflowErr); end
      stackOp(2'd1, 1'b0, 16'h0007, pv, pd, pa);
      stackOp(2'd2, 1'b0, 16'h0, pv, pd, pa);
      total++; if (pv !== 1'b1 || pd !== 16'h0007) begin bad++; $display("FAIL unf_recover got %b/%h want 1/0007", pv, pd); end
   endtask

   task automatic test_hold_noop();
      logic pv, pa; logic [15:0] pd;
      bus.enMem = 1'b1; bus.sigStackMem = 1'b1; bus.sigNewSP = 2'd1; bus.regData = 16'h0055;
      repeat (4) @(posedge clock);
      #1 idle();
      @(posedge clock); #1;
      total++; if (bus.sp !== 4'd1) begin bad++; $display("FAIL hold_sp got %0d want 1", bus.sp); end
      bus.enMem = 1'b1; bus.sigStackMem = 1'b0; bus.sigNewSP = 2'd1;
      @(posedge clock); #1 bus.sigStackMem = 1'b1; bus.sigNewSP = 2'd3;
      @(posedge clock); #1 idle();
      @(posedge clock); #1;
      total++; if (bus.sp !== 4'd1) begin bad++; $display("FAIL noop_sp got %0d want 1", bus.sp); end
      stackOp(2'd2, 1'b0, 16'h0, pv, pd, pa);
      total++; if (pv !== 1'b1 || pd !== 16'h0055) begin bad++; $display("FAIL hold_pop got %b/%h want 1/0055", pv, pd); end
   endtask

   task automatic test_reset_cmd();
      logic pv, pa; logic [15:0] pd;
      bus.enMem = 1'b1; bus.sigStackMem = 1'b1; bus.sigNewSP = 2'd1; bus.regData = 16'hBEEF;
      reset_n = 1'b0;
      @(posedge clock); #1;
      idle(); reset_n = 1'b1;
      @(posedge clock); #1;
      total++; if (bus.sp !== 4'd0) begin bad++; $display("FAIL rstcmd_sp got %0d want 0", bus.sp); end
      total++; if (bus.emptyFlag !== 1'b1) begin bad++; $display("FAIL rstcmd_empty got %b want 1", bus.emptyFlag); end
      total++; if (bus.overflowErr !== 1'b0 || bus.underflowErr !== 1'b0) begin bad++; $display("FAIL rstcmd_errs got %b%b want 00", bus.overflowErr, bus.underflowErr); end
      total++; if (bus.popData !== 16'h0) begin bad++; $display("FAIL rstcmd_popData got %h want 0000", bus.popData); end
      stackOp(2'd2, 1'b0, 16'h0, pv, pd, pa);
      total++; if (pv !== 1'b0 || bus.underflowErr !== 1'b1) begin bad++; $display("FAIL rstcmd_pop got %b/%b want 0/1", pv, bus.underflowErr); end
   endtask

   initial begin
      idle();
      test_reset();
      test_call();
      test_push_pop();
      test_full();
      test_underflow();
      test_hold_noop();
      test_reset_cmd();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
